dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Two-requester arbiter and access sequencer for the single-port 32x8 data memory of the multi-cycle stack-based MIPS.
- Requester 0: main datapath load/store.
- Requester 1: stack push/pop unit.
- It latches each granted request and drives the memory's adr/data/sig_read/sig_write strobes for a fixed access window. It then captures read data and returns a one-cycle done pulse to the granted requester.
- Arbitration is round-robin, so neither requester starves.

Parameters:
ADR_W, 5, memory address width
DATA_W, 8, memory data width
ACCESS_CYCLES, 2, cycles the memory strobes are held per access; legal range 1..15

Ports:
clk  in  1  system clock, rising-edge
rst  in  1  asynchronous, active-low reset
m0_req  in  1  requester 0 access request
m0_we  in  1  requester 0: 1 = write, 0 = read
m0_adr  in  ADR_W  requester 0 address
m0_wdata  in  DATA_W  requester 0 write data
m0_rdata  out  DATA_W  requester 0 read data, registered
m0_done  out  1  requester 0 completion pulse
m1_req, m1_we, m1_adr, m1_wdata, m1_rdata, m1_done: same as m0_* for requester 1
mem_adr  out  ADR_W  to memory adr
mem_data  out  DATA_W  to memory data
mem_read  out  1  to memory sig_read
mem_write  out  1  to memory sig_write
mem_out  in  DATA_W  from memory out
busy  out  1  high while the FSM is in ACCESS or DONE
grant_id  out  1  requester currently or last granted

Behaviour:
- Reset (rst=0, asynchronous) forces the following immediately, including mid-access:
  - state=IDLE
  - mem_read=0, mem_write=0, mem_adr=0, mem_data=0
  - m0_done=m1_done=0, m0_rdata=m1_rdata=0
  - busy=0, counter=0
  - grant_id=1, so requester 0 wins the first tie
- States: IDLE, ACCESS, DONE. All outputs are registered.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req high: grant it.
  - Both req high: grant the requester != grant_id (round-robin).
  - On grant, at the clock edge:
    - latch we/adr/wdata of the winner
    - update grant_id
    - load counter=ACCESS_CYCLES-1
    - go to ACCESS
- ACCESS:
  - mem_adr = latched address; mem_data = latched wdata.
  - mem_read = !we_latched; mem_write = we_latched. The two strobes are never both high.
  - Counter decrements each cycle. At counter==0 go to DONE. On that same edge, a read captures mem_out into the granted requester's rdata.
  - Strobes are high for exactly ACCESS_CYCLES cycles.
- DONE:
  - mem_read=mem_write=0; mem_adr and mem_data hold their values.
  - The granted requester's done is high for exactly one cycle. Next state is IDLE.
- Latency: req sampled high in IDLE -> done high 1+ACCESS_CYCLES edges later. With default ACCESS_CYCLES=2, done is high in the 3rd cycle after the grant edge.
- Back-to-back rate: 1 idle cycle between accesses. A full transaction is ACCESS_CYCLES+2 cycles.
- Requester protocol:
  - Hold req plus inputs stable until the grant edge. Inputs are don't-care after the grant.
  - Drop req on the edge where its done is seen high.
  - If req is still high in IDLE, it is treated as a new request. Round-robin then favours the other requester if both are requesting.
- rdata holds its value until that requester's next read completes. Writes never alter rdata.
- A req arriving during ACCESS/DONE is ignored until IDLE. It is not queued separately.
- The non-granted requester's done stays 0 throughout.

Test Plan:
- Reset: rst=0 during ACCESS with mem_read high -> mem_read=0, busy=0, grant_id=1, all rdata=0 with no clock edge; after release, IDLE.
- Single write then read: m0 write adr=5 wdata=0xA7 -> mem_write high 2 cycles with mem_adr=5, mem_data=0xA7, then m0_done pulse. Then m0 read adr=5 -> m0_rdata=0xA7 and m0_done exactly 3 cycles after grant.
- Simultaneous requests from reset: m0 read adr=3, m1 write adr=31 data=0x5C, both req high -> m0 served first, then m1. Neither done overlaps; grant_id sequence 0, 1.
- Fairness: both req held high continuously for 8 transactions -> grants alternate 0, 1, 0, 1...; each requester gets 4.
- Isolation: m1 read adr=31 after the write of 0x5C -> m1_rdata=0x5C; m0_rdata unchanged at 0xA7; m0_done stays 0.
- Parameter sweep: ACCESS_CYCLES=1 and 15 -> strobe width equals parameter; done at 1+ACCESS_CYCLES edges after grant.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the data-memory arbiter, its two requesters and the memory.
// The arbiter takes the slave view; whoever drives the requesters and the memory takes the master view.
interface dmem_arbiter_if #(
    parameter int ADR_W  = 5,
    parameter int DATA_W = 8
);
    logic              m0_req;
    logic              m0_we;
    logic [ADR_W-1:0]  m0_adr;
    logic [DATA_W-1:0] m0_wdata;
    logic [DATA_W-1:0] m0_rdata;
    logic              m0_done;

    logic              m1_req;
    logic              m1_we;
    logic [ADR_W-1:0]  m1_adr;
    logic [DATA_W-1:0] m1_wdata;
    logic [DATA_W-1:0] m1_rdata;
    logic              m1_done;

    logic [ADR_W-1:0]  mem_adr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_out;

    logic              busy;
    logic              grant_id;

    modport slave (
        input  m0_req, m0_we, m0_adr, m0_wdata,
        input  m1_req, m1_we, m1_adr, m1_wdata,
        input  mem_out,
        output m0_rdata, m0_done, m1_rdata, m1_done,
        output mem_adr, mem_data, mem_read, mem_write,
        output busy, grant_id
    );

    modport master (
        output m0_req, m0_we, m0_adr, m0_wdata,
        output m1_req, m1_we, m1_adr, m1_wdata,
        output mem_out,
        input  m0_rdata, m0_done, m1_rdata, m1_done,
        input  mem_adr, mem_data, mem_read, mem_write,
        input  busy, grant_id
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and access sequencer for the single-port data memory shared by
// the datapath load/store path (requester 0) and the stack push/pop unit (requester 1).
module dmem_arbiter #(
    parameter int ADR_W         = 5,
    parameter int DATA_W        = 8,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              grant_q, grant_d;
    logic              busy_q, busy_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [ADR_W-1:0]  adr_q, adr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              done0_q, done0_d;
    logic              done1_q, done1_d;

    logic              anyReq;
    logic              winner;
    logic              winWe;

    // On a tie the requester that did not win last time goes next.
    assign anyReq = bus.m0_req | bus.m1_req;
    assign winner = (bus.m0_req && bus.m1_req) ? ~grant_q : bus.m1_req;
    assign winWe  = winner ? bus.m1_we : bus.m0_we;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            grant_q  <= 1'b1;
            busy_q   <= 1'b0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            adr_q    <= '0;
            data_q   <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            grant_q  <= grant_d;
            busy_q   <= busy_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            adr_q    <= adr_d;
            data_q   <= data_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            done0_q  <= done0_d;
            done1_q  <= done1_d;
        end
    end

    // Strobes are raised on the grant edge and dropped on the edge that leaves ACCESS,
    // so they stay high for exactly ACCESS_CYCLES cycles.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        grant_d  = grant_q;
        busy_d   = busy_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        adr_d    = adr_q;
        data_d   = data_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        done0_d  = done0_q;
        done1_d  = done1_q;

        case (state_q)
            IDLE: begin
                if (anyReq) begin
                    state_d = ACCESS;
                    grant_d = winner;
                    cnt_d   = CNT_LOAD;
                    busy_d  = 1'b1;
                    adr_d   = winner ? bus.m1_adr : bus.m0_adr;
                    data_d  = winner ? bus.m1_wdata : bus.m0_wdata;
                    wr_d    = winWe;
                    rd_d    = ~winWe;
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    if (grant_q) begin
                        done1_d = 1'b1;
                    end else begin
                        done0_d = 1'b1;
                    end
                    if (rd_q && grant_q) begin
                        rdata1_d = bus.mem_out;
                    end else if (rd_q) begin
                        rdata0_d = bus.mem_out;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done0_d = 1'b0;
                done1_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.mem_adr   = adr_q;
    assign bus.mem_data  = data_q;
    assign bus.mem_read  = rd_q;
    assign bus.mem_write = wr_q;
    assign bus.m0_rdata  = rdata0_q;
    assign bus.m1_rdata  = rdata1_q;
    assign bus.m0_done   = done0_q;
    assign bus.m1_done   = done1_q;
    assign bus.busy      = busy_q;
    assign bus.grant_id  = grant_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a randomized phase scored
// against a transaction-level model, and a strobe/latency sweep on ACCESS_CYCLES = 1 and 15.
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;

    int testsRun    = 0;
    int testsFailed = 0;

    dmem_arbiter_if #(.ADR_W(5), .DATA_W(8)) bus ();
    dmem_arbiter_if #(.ADR_W(5), .DATA_W(8)) b1 ();
    dmem_arbiter_if #(.ADR_W(5), .DATA_W(8)) b15 ();

    dmem_arbiter #(.ADR_W(5), .DATA_W(8), .ACCESS_CYCLES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
    dmem_arbiter #(.ADR_W(5), .DATA_W(8), .ACCESS_CYCLES(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );
    dmem_arbiter #(.ADR_W(5), .DATA_W(8), .ACCESS_CYCLES(15)) dut15 (
        .clk (clk),
        .rst (rst),
        .bus (b15)
    );

    always #5 clk = ~clk;

    // Memory the main arbiter drives; combinational read, write on the clock edge.
    logic [7:0] tbMem [32] = '{default: 8'h00};
    assign bus.mem_out = tbMem[bus.mem_adr];
    always @(posedge clk) begin
        if (bus.mem_write) tbMem[bus.mem_adr] <= bus.mem_data;
    end
    assign b1.mem_out  = 8'h3C;
    assign b15.mem_out = 8'h3C;

    // Transaction-level reference model state.
    logic [7:0] refMem [32];
    logic [7:0] expRdata [2];
    int         lastGrant;

    bit         pend [2];
    logic       rWe [2];
    logic [4:0] rAdr [2];
    logic [7:0] rWd [2];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int who, input bit req, input bit we,
                                 input logic [4:0] adr, input logic [7:0] wd);
        if (who == 0) begin
            bus.m0_req = req; bus.m0_we = we; bus.m0_adr = adr; bus.m0_wdata = wd;
        end else begin
            bus.m1_req = req; bus.m1_we = we; bus.m1_adr = adr; bus.m1_wdata = wd;
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Starts at an IDLE negedge with the winner's request applied; ends at the following IDLE negedge.
    task automatic checkTxn(input int who, input bit we, input logic [4:0] adr,
                            input logic [7:0] wd, input bit dropReq);
        step();
        for (int k = 0; k < 2; k++) begin
            if (k > 0) step();
            checkOutput("acc_busy", 32'(bus.busy), 32'd1);
            checkOutput("acc_grant_id", 32'(bus.grant_id), 32'(who));
            checkOutput("acc_mem_read", 32'(bus.mem_read), 32'(!we));
            checkOutput("acc_mem_write", 32'(bus.mem_write), 32'(we));
            checkOutput("acc_mem_adr", 32'(bus.mem_adr), 32'(adr));
            checkOutput("acc_mem_data", 32'(bus.mem_data), 32'(wd));
            checkOutput("acc_m0_done", 32'(bus.m0_done), 32'd0);
            checkOutput("acc_m1_done", 32'(bus.m1_done), 32'd0);
        end
        if (we) refMem[adr] = wd;
        else    expRdata[who] = refMem[adr];
        lastGrant = who;
        step();
        checkOutput("done_m0_done", 32'(bus.m0_done), 32'(who == 0));
        checkOutput("done_m1_done", 32'(bus.m1_done), 32'(who == 1));
        checkOutput("done_mem_read", 32'(bus.mem_read), 32'd0);
        checkOutput("done_mem_write", 32'(bus.mem_write), 32'd0);
        checkOutput("done_mem_adr", 32'(bus.mem_adr), 32'(adr));
        checkOutput("done_busy", 32'(bus.busy), 32'd1);
        checkOutput("done_m0_rdata", 32'(bus.m0_rdata), 32'(expRdata[0]));
        checkOutput("done_m1_rdata", 32'(bus.m1_rdata), 32'(expRdata[1]));
        if (dropReq) applyStimulus(who, 1'b0, we, adr, wd);
        step();
        checkOutput("idle_m0_done", 32'(bus.m0_done), 32'd0);
        checkOutput("idle_m1_done", 32'(bus.m1_done), 32'd0);
        checkOutput("idle_busy", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int cnt0;
        int cnt1;
        int w;
        int width1;
        int width15;
        int done1At;
        int done15At;

        for (int i = 0; i < 32; i++) refMem[i] = 8'h00;
        expRdata[0] = 8'h00;
        expRdata[1] = 8'h00;
        lastGrant   = 1;
        applyStimulus(0, 1'b0, 1'b0, 5'd0, 8'h00);
        applyStimulus(1, 1'b0, 1'b0, 5'd0, 8'h00);
        b1.m0_req = 1'b0;  b1.m0_we = 1'b0;  b1.m0_adr = 5'd0;  b1.m0_wdata = 8'h00;
        b1.m1_req = 1'b0;  b1.m1_we = 1'b0;  b1.m1_adr = 5'd0;  b1.m1_wdata = 8'h00;
        b15.m0_req = 1'b0; b15.m0_we = 1'b0; b15.m0_adr = 5'd0; b15.m0_wdata = 8'h00;
        b15.m1_req = 1'b0; b15.m1_we = 1'b0; b15.m1_adr = 5'd0; b15.m1_wdata = 8'h00;

        // Reset state.
        step();
        step();
        checkOutput("rst_mem_read", 32'(bus.mem_read), 32'd0);
        checkOutput("rst_mem_write", 32'(bus.mem_write), 32'd0);
        checkOutput("rst_mem_adr", 32'(bus.mem_adr), 32'd0);
        checkOutput("rst_mem_data", 32'(bus.mem_data), 32'd0);
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_grant_id", 32'(bus.grant_id), 32'd1);
        checkOutput("rst_m0_rdata", 32'(bus.m0_rdata), 32'd0);
        checkOutput("rst_m1_rdata", 32'(bus.m1_rdata), 32'd0);
        checkOutput("rst_m0_done", 32'(bus.m0_done), 32'd0);
        rst = 1'b1;
        step();
        checkOutput("post_rst_busy", 32'(bus.busy), 32'd0);

        // Single write then read by requester 0.
        applyStimulus(0, 1'b1, 1'b1, 5'd5, 8'hA7);
        checkTxn(0, 1'b1, 5'd5, 8'hA7, 1'b1);
        applyStimulus(0, 1'b1, 1'b0, 5'd5, 8'h00);
        checkTxn(0, 1'b0, 5'd5, 8'h00, 1'b1);
        checkOutput("wr_rd_m0_rdata", 32'(bus.m0_rdata), 32'h0000_00A7);

        // Asynchronous reset in the middle of a read access.
        applyStimulus(0, 1'b1, 1'b0, 5'd5, 8'h00);
        step();
        checkOutput("midrst_pre_read", 32'(bus.mem_read), 32'd1);
        rst = 1'b0;
        #1;
        checkOutput("midrst_mem_read", 32'(bus.mem_read), 32'd0);
        checkOutput("midrst_busy", 32'(bus.busy), 32'd0);
        checkOutput("midrst_grant_id", 32'(bus.grant_id), 32'd1);
        checkOutput("midrst_m0_rdata", 32'(bus.m0_rdata), 32'd0);
        checkOutput("midrst_m1_rdata", 32'(bus.m1_rdata), 32'd0);
        checkOutput("midrst_mem_adr", 32'(bus.mem_adr), 32'd0);
        applyStimulus(0, 1'b0, 1'b0, 5'd0, 8'h00);
        expRdata[0] = 8'h00;
        expRdata[1] = 8'h00;
        lastGrant   = 1;
        step();
        rst = 1'b1;
        step();
        checkOutput("midrst_idle_busy", 32'(bus.busy), 32'd0);
        checkOutput("midrst_idle_write", 32'(bus.mem_write), 32'd0);

        // Simultaneous requests straight out of reset: requester 0 first, then 1.
        applyStimulus(0, 1'b1, 1'b0, 5'd3, 8'h00);
        applyStimulus(1, 1'b1, 1'b1, 5'd31, 8'h5C);
        checkTxn(0, 1'b0, 5'd3, 8'h00, 1'b1);
        checkTxn(1, 1'b1, 5'd31, 8'h5C, 1'b1);

        // Requester 0 re-reads 0xA7, then isolation of requester 1's read.
        applyStimulus(0, 1'b1, 1'b0, 5'd5, 8'h00);
        checkTxn(0, 1'b0, 5'd5, 8'h00, 1'b1);
        applyStimulus(1, 1'b1, 1'b0, 5'd31, 8'h00);
        checkTxn(1, 1'b0, 5'd31, 8'h00, 1'b1);
        checkOutput("iso_m1_rdata", 32'(bus.m1_rdata), 32'h0000_005C);
        checkOutput("iso_m0_rdata", 32'(bus.m0_rdata), 32'h0000_00A7);

        // Fairness with both requests held continuously.
        rWd[0] = 8'($urandom);
        applyStimulus(0, 1'b1, 1'b1, 5'd10, rWd[0]);
        applyStimulus(1, 1'b1, 1'b0, 5'd31, 8'h00);
        cnt0 = 0;
        cnt1 = 0;
        for (int i = 0; i < 8; i++) begin
            w = (lastGrant == 0) ? 1 : 0;
            if (w == 0) begin
                checkTxn(0, 1'b1, 5'd10, rWd[0], 1'b0);
                cnt0++;
            end else begin
                checkTxn(1, 1'b0, 5'd31, 8'h00, 1'b0);
                cnt1++;
            end
        end
        checkOutput("fair_m0_grants", 32'(cnt0), 32'd4);
        checkOutput("fair_m1_grants", 32'(cnt1), 32'd4);
        applyStimulus(0, 1'b0, 1'b0, 5'd0, 8'h00);
        applyStimulus(1, 1'b0, 1'b0, 5'd0, 8'h00);
        step();

        // Randomized traffic; a pending request keeps its inputs until granted.
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        for (int it = 0; it < 30; it++) begin
            for (int r = 0; r < 2; r++) begin
                if (!pend[r]) begin
                    pend[r] = 1'($urandom_range(0, 1));
                    rWe[r]  = 1'($urandom_range(0, 1));
                    rAdr[r] = 5'($urandom);
                    rWd[r]  = 8'($urandom);
                    applyStimulus(r, pend[r], rWe[r], rAdr[r], rWd[r]);
                end
            end
            if (!pend[0] && !pend[1]) begin
                step();
                checkOutput("rnd_idle_busy", 32'(bus.busy), 32'd0);
                checkOutput("rnd_idle_grant", 32'(bus.grant_id), 32'(lastGrant));
            end else begin
                if (pend[0] && pend[1]) w = 1 - lastGrant;
                else                    w = pend[1] ? 1 : 0;
                checkTxn(w, rWe[w], rAdr[w], rWd[w], 1'b1);
                pend[w] = 1'b0;
            end
        end

        // ACCESS_CYCLES sweep: strobe width and done latency after the grant edge.
        b1.m0_req  = 1'b1; b1.m0_adr  = 5'd7;
        b15.m0_req = 1'b1; b15.m0_adr = 5'd7;
        width1   = 0;
        width15  = 0;
        done1At  = 0;
        done15At = 0;
        for (int c = 1; c <= 30; c++) begin
            step();
            if (b1.mem_read)  width1++;
            if (b15.mem_read) width15++;
            if (b1.m0_done && done1At == 0) begin
                done1At   = c;
                b1.m0_req = 1'b0;
            end
            if (b15.m0_done && done15At == 0) begin
                done15At   = c;
                b15.m0_req = 1'b0;
            end
        end
        checkOutput("ac1_strobe_width", 32'(width1), 32'd1);
        checkOutput("ac1_done_cycle", 32'(done1At), 32'd2);
        checkOutput("ac1_rdata", 32'(b1.m0_rdata), 32'h0000_003C);
        checkOutput("ac15_strobe_width", 32'(width15), 32'd15);
        checkOutput("ac15_done_cycle", 32'(done15At), 32'd16);
        checkOutput("ac15_rdata", 32'(b15.m0_rdata), 32'h0000_003C);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
